// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU types used by the memory arbiter and its timer.
//   word_t       : 32-bit machine word
//   arb_state_t  : arbiter FSM states (IDLE, IACC, DACC)
//   grant_side_t : which requester won the most recent grant
//   TIMER_W      : width of the arbiter timeout counter (TIMEOUT is 1..255)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_side_t;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
//   Counts granted cycles that have not yet seen ramready and flags the
//   cycle in which the count would reach TIMEOUT.
//   Parameters:
//     TIMEOUT  : number of stalled granted cycles allowed (1..255)
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     clear_i  in   zero the counter (held while the arbiter is idle)
//     enable_i in   count this cycle (granted, request live, no ramready)
//     expire_o out  this enabled cycle is the TIMEOUT-th stalled cycle
module mem_arb_timer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear wins over enable so a fresh grant always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire fires in the stalled cycle that would bring the count to
    // TIMEOUT, so the arbiter leaves after exactly TIMEOUT stalled cycles.
    assign expire_o = enable_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single RAM port between instruction fetch and data access.
//   An FSM grants one requester per access and forwards that requester's
//   live command to the RAM until ramready, a withdrawal, or a timeout.
//   Optional macro: MEM_ARB_FAIR_EN
//     defined   : ties in IDLE go to the side that lost the previous grant
//     undefined : ties in IDLE always go to the data side
//   Parameters:
//     TIMEOUT    : stalled granted cycles before an access is aborted (1..255)
//   Ports:
//     clk, rst_n                  clock / asynchronous active-low reset
//     iREN_i, iaddr_i             instruction read request and address
//     iwait_o, iload_o            instruction not done / fetched word
//     dREN_i, dWEN_i              data read / write request (write dominates)
//     daddr_i, dstore_i           data address / write data
//     dwait_o, dload_o            data not done / read data
//     ramREN_o, ramWEN_o          RAM read / write strobes
//     ramaddr_o, ramstore_o       RAM address / write data
//     ramload_i, ramready_i       RAM read data / access complete
//     arb_err_o                   sticky: some access timed out
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  iREN_i,
    input  word_t iaddr_i,
    output logic  iwait_o,
    output word_t iload_o,
    input  logic  dREN_i,
    input  logic  dWEN_i,
    input  word_t daddr_i,
    input  word_t dstore_i,
    output logic  dwait_o,
    output word_t dload_o,
    output logic  ramREN_o,
    output logic  ramWEN_o,
    output word_t ramaddr_o,
    output word_t ramstore_o,
    input  word_t ramload_i,
    input  logic  ramready_i,
    output logic  arb_err_o
);

    arb_state_t state_q;
    logic       arb_err_q;
`ifdef MEM_ARB_FAIR_EN
    grant_side_t last_grant_q;
`endif

    logic iReq;
    logic dReq;
    logic dWins;
    logic iDone;
    logic dDone;
    logic grantLive;
    logic timerClear;
    logic timerEnable;
    logic timerExpire;

    assign iReq = iREN_i;
    assign dReq = dREN_i | dWEN_i;

    // Tie resolution used only when deciding a grant from IDLE.
`ifdef MEM_ARB_FAIR_EN
    assign dWins = dReq && (!iReq || (last_grant_q == GRANT_I));
`else
    assign dWins = dReq;
`endif

    // A completion only counts while the granted requester still asks;
    // a withdrawn request never sees a hit even if ramready arrives.
    assign iDone     = (state_q == IACC) && iReq && ramready_i;
    assign dDone     = (state_q == DACC) && dReq && ramready_i;
    assign grantLive = ((state_q == IACC) && iReq) || ((state_q == DACC) && dReq);

    assign timerClear  = (state_q == IDLE);
    assign timerEnable = grantLive && !ramready_i;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timerClear),
        .enable_i (timerEnable),
        .expire_o (timerExpire)
    );

    // Arbiter FSM: grant from IDLE, return to IDLE on completion,
    // withdrawal or timeout; timeout also latches the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            arb_err_q    <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (dWins) begin
                        state_q <= DACC;
`ifdef MEM_ARB_FAIR_EN
                        last_grant_q <= GRANT_D;
`endif
                    end else if (iReq) begin
                        state_q <= IACC;
`ifdef MEM_ARB_FAIR_EN
                        last_grant_q <= GRANT_I;
`endif
                    end
                end
                IACC: begin
                    if (!iReq || ramready_i) begin
                        state_q <= IDLE;
                    end else if (timerExpire) begin
                        state_q   <= IDLE;
                        arb_err_q <= 1'b1;
                    end
                end
                DACC: begin
                    if (!dReq || ramready_i) begin
                        state_q <= IDLE;
                    end else if (timerExpire) begin
                        state_q   <= IDLE;
                        arb_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM command follows the granted requester's live inputs so a
    // withdrawn request drops its strobe in the same cycle.
    always_comb begin
        ramREN_o   = 1'b0;
        ramWEN_o   = 1'b0;
        ramaddr_o  = '0;
        ramstore_o = '0;
        case (state_q)
            IACC: begin
                ramREN_o  = iREN_i;
                ramaddr_o = iaddr_i;
            end
            DACC: begin
                ramWEN_o   = dWEN_i;
                ramREN_o   = dREN_i && !dWEN_i;
                ramaddr_o  = daddr_i;
                ramstore_o = dstore_i;
            end
            default: begin
                ramREN_o = 1'b0;
            end
        endcase
    end

    assign iwait_o   = iReq && !iDone;
    assign dwait_o   = dReq && !dDone;
    assign iload_o   = iDone ? ramload_i : '0;
    assign dload_o   = dDone ? ramload_i : '0;
    assign arb_err_o = arb_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (TIMEOUT=4). Expected completions are
//   queued as stimulus is issued; a negedge monitor pops one entry every
//   time the DUT signals a hit and compares side and returned word.
module tb_mem_arbiter;

    typedef struct {
        bit          isData;
        logic [31:0] data;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic        iRen;
    logic [31:0] iAddr;
    logic        iWait;
    logic [31:0] iLoad;
    logic        dRen;
    logic        dWen;
    logic [31:0] dAddr;
    logic [31:0] dStore;
    logic        dWait;
    logic [31:0] dLoad;
    logic        ramRen;
    logic        ramWen;
    logic [31:0] ramAddr;
    logic [31:0] ramStore;
    logic [31:0] ramLoad;
    logic        ramReady;
    logic        arbErr;

    int total = 0;
    int bad   = 0;
    expEntry_t sbQ[$];
    bit expectD;

    mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iREN_i     (iRen),
        .iaddr_i    (iAddr),
        .iwait_o    (iWait),
        .iload_o    (iLoad),
        .dREN_i     (dRen),
        .dWEN_i     (dWen),
        .daddr_i    (dAddr),
        .dstore_i   (dStore),
        .dwait_o    (dWait),
        .dload_o    (dLoad),
        .ramREN_o   (ramRen),
        .ramWEN_o   (ramWen),
        .ramaddr_o  (ramAddr),
        .ramstore_o (ramStore),
        .ramload_i  (ramLoad),
        .ramready_i (ramReady),
        .arb_err_o  (arbErr)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Move to just after the next rising edge so new inputs settle early.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] ds);
        iRen   = ir;
        iAddr  = ia;
        dRen   = dr;
        dWen   = dw;
        dAddr  = da;
        dStore = ds;
    endtask

    // RAM answers this cycle; the expected hit is queued for the monitor.
    task automatic ramRespond(input bit isData, input logic [31:0] data);
        expEntry_t e;
        ramReady = 1'b1;
        ramLoad  = data;
        e.isData = isData;
        e.data   = data;
        sbQ.push_back(e);
    endtask

    task automatic ramIdle();
        ramReady = 1'b0;
        ramLoad  = '0;
    endtask

    // Monitor: every hit must match the oldest queued expectation.
    always @(negedge clk) begin
        expEntry_t e;
        if (rst_n && iRen && !iWait) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_ihit", iLoad, 32'hFFFF_FFFF);
            end else begin
                e = sbQ.pop_front();
                checkOutput("ihit_side", 32'(iLoad != 0 ? 0 : 0) | 32'(e.isData), 32'd0);
                checkOutput("iload", iLoad, e.data);
            end
        end
        if (rst_n && (dRen || dWen) && !dWait) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_dhit", dLoad, 32'hFFFF_FFFF);
            end else begin
                e = sbQ.pop_front();
                checkOutput("dhit_side", 32'(e.isData), 32'd1);
                checkOutput("dload", dLoad, e.data);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef MEM_ARB_FAIR_EN
        expectD = 1'b0;
`else
        expectD = 1'b1;
`endif
        // Reset with a fetch already requested.
        rst_n = 1'b0;
        ramIdle();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst_ramREN", 32'(ramRen), 32'd0);
        checkOutput("rst_ramaddr", ramAddr, 32'd0);
        checkOutput("rst_iwait", 32'(iWait), 32'd1);
        checkOutput("rst_arb_err", 32'(arbErr), 32'd0);
        checkOutput("rst_ramWEN", 32'(ramWen), 32'd0);

        // Release: one IDLE cycle, then the fetch is granted.
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ramREN", 32'(ramRen), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("iacc_ramREN", 32'(ramRen), 32'd1);
        checkOutput("iacc_ramaddr", ramAddr, 32'h40);
        checkOutput("iacc_iwait", 32'(iWait), 32'd1);

        // Fetch completes on the second granted cycle.
        nextCycle();
        ramRespond(1'b0, 32'h8C22_0004);
        @(negedge clk);
        checkOutput("fetch_iwait", 32'(iWait), 32'd0);
        nextCycle();
        ramIdle();
        applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("fetch_done_ramREN", 32'(ramRen), 32'd0);
        checkOutput("fetch_done_iload", iLoad, 32'd0);

        // Tie: data wins first in both builds (previous grant was I).
        nextCycle();
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        checkOutput("tie_idle_iwait", 32'(iWait), 32'd1);
        checkOutput("tie_idle_dwait", 32'(dWait), 32'd1);
        nextCycle();
        ramRespond(1'b1, 32'h1111_1111);
        @(negedge clk);
        checkOutput("tie1_ramaddr", ramAddr, 32'h200);
        checkOutput("tie1_loser_iwait", 32'(iWait), 32'd1);
        nextCycle();
        ramIdle();
        @(negedge clk);
        checkOutput("tie_gap_ramREN", 32'(ramRen), 32'd0);
        // Persistent tie: fixed priority repeats D, fair mode switches to I.
        nextCycle();
        ramRespond(expectD, 32'h3333_3333);
        @(negedge clk);
        checkOutput("tie2_ramaddr", ramAddr, expectD ? 32'h200 : 32'h80);
        nextCycle();
        ramIdle();
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        checkOutput("tie_drop_ramREN", 32'(ramRen), 32'd0);
        nextCycle();
        ramRespond(1'b0, 32'h4444_4444);
        @(negedge clk);
        checkOutput("tie3_ramaddr", ramAddr, 32'h80);
        nextCycle();
        ramIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Store with dREN and dWEN both set: write dominates.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("st_idle_ramWEN", 32'(ramWen), 32'd0);
        checkOutput("st_idle_dwait", 32'(dWait), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("st_ramWEN", 32'(ramWen), 32'd1);
        checkOutput("st_ramREN", 32'(ramRen), 32'd0);
        checkOutput("st_ramstore", ramStore, 32'hDEAD_BEEF);
        checkOutput("st_ramaddr", ramAddr, 32'h100);
        checkOutput("st_dwait", 32'(dWait), 32'd1);
        nextCycle();
        ramRespond(1'b1, 32'h0);
        @(negedge clk);
        checkOutput("st_done_dwait", 32'(dWait), 32'd0);
        nextCycle();
        ramIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("st_after_ramWEN", 32'(ramWen), 32'd0);
        checkOutput("st_after_ramstore", ramStore, 32'd0);

        // Flush: fetch withdrawn while granted, even with ramready present.
        nextCycle();
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("fl_ramREN", 32'(ramRen), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'hC0, 1'b0, 1'b0, 32'h0, 32'h0);
        ramReady = 1'b1;
        ramLoad  = 32'hBAD0_BAD0;
        @(negedge clk);
        checkOutput("fl_drop_ramREN", 32'(ramRen), 32'd0);
        checkOutput("fl_drop_iload", iLoad, 32'd0);
        nextCycle();
        ramIdle();
        @(negedge clk);
        checkOutput("fl_idle_ramaddr", ramAddr, 32'd0);

        // Timeout: four stalled granted cycles, then IDLE with sticky error.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("to_ramREN_%0d", i), 32'(ramRen), 32'd1);
            checkOutput($sformatf("to_arb_err_%0d", i), 32'(arbErr), 32'd0);
            checkOutput($sformatf("to_dload_%0d", i), dLoad, 32'd0);
        end
        nextCycle();
        @(negedge clk);
        checkOutput("to_idle_ramREN", 32'(ramRen), 32'd0);
        checkOutput("to_idle_dwait", 32'(dWait), 32'd1);
        checkOutput("to_arb_err", 32'(arbErr), 32'd1);
        // A later access still completes normally.
        nextCycle();
        ramRespond(1'b1, 32'h5555_5555);
        @(negedge clk);
        checkOutput("to_retry_ramaddr", ramAddr, 32'h300);
        nextCycle();
        ramIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("to_sticky_arb_err", 32'(arbErr), 32'd1);

        // Every queued completion must have been observed.
        checkOutput("sb_leftover", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
